// File: rtl/conv_feeder_if.sv
// Stream bundle between conv_feeder and its neighbours: weight/bias load,
// sample input, and the i/k/b operand streams plus frame flag toward the MAC.
interface conv_feeder_if #(
    parameter int unsigned W = 8
);
    logic         load_i;
    logic         w_TVALID;
    logic         w_TREADY;
    logic [W-1:0] w_TDATA;
    logic         s_TVALID;
    logic         s_TREADY;
    logic [W-1:0] s_TDATA;
    logic         i_TVALID;
    logic         i_TREADY;
    logic [W-1:0] i_TDATA;
    logic         k_TVALID;
    logic         k_TREADY;
    logic [W-1:0] k_TDATA;
    logic         b_TVALID;
    logic         b_TREADY;
    logic [W-1:0] b_TDATA;
    logic         new_o;

    // Feeder side
    modport master (
        input  load_i,
        input  w_TVALID, w_TDATA,
        output w_TREADY,
        input  s_TVALID, s_TDATA,
        output s_TREADY,
        output i_TVALID, i_TDATA,
        input  i_TREADY,
        output k_TVALID, k_TDATA,
        input  k_TREADY,
        output b_TVALID, b_TDATA,
        input  b_TREADY,
        output new_o
    );

    // Environment side (loader, sample source, MAC)
    modport slave (
        output load_i,
        output w_TVALID, w_TDATA,
        input  w_TREADY,
        output s_TVALID, s_TDATA,
        input  s_TREADY,
        input  i_TVALID, i_TDATA,
        output i_TREADY,
        input  k_TVALID, k_TDATA,
        output k_TREADY,
        input  b_TVALID, b_TDATA,
        output b_TREADY,
        input  new_o
    );
endinterface

// File: rtl/conv_feeder.sv
// Operand feeder for the stream MAC: TAPS-deep sample window and loadable
// weights/bias, streamed as one framed burst of TAPS pairs plus a bias per sample.
module conv_feeder #(
    parameter int unsigned TAPS = 4,
    parameter int unsigned W    = 8
) (
    input  logic          clk,
    input  logic          reset,
    conv_feeder_if.master bus
);
    localparam int unsigned TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned WW = $clog2(TAPS + 1);

    typedef logic [W-1:0] data_t;

    typedef enum logic [1:0] {
        S_LOAD,
        S_IDLE,
        S_EMIT,
        S_EMIT_BIAS
    } state_t;

    state_t        state_q;
    data_t         win_q [TAPS];
    data_t         wt_q  [TAPS];
    data_t         bias_q;
    logic [WW-1:0] widx_q;
    logic [TW-1:0] tap_q;
    logic          bias_done_q;

    logic pair_xfer;
    logic bias_xfer;
    logic last_tap;

    assign pair_xfer = (state_q == S_EMIT) & bus.i_TREADY & bus.k_TREADY;
    assign bias_xfer = (state_q == S_EMIT) & ~bias_done_q & bus.b_TREADY;
    assign last_tap  = (tap_q == TW'(TAPS - 1));

    // Outputs decoded from registered state; only s_TREADY sees load_i directly
    assign bus.w_TREADY = (state_q == S_LOAD);
    assign bus.s_TREADY = (state_q == S_IDLE) & ~bus.load_i;
    assign bus.i_TVALID = (state_q == S_EMIT);
    assign bus.k_TVALID = (state_q == S_EMIT);
    assign bus.b_TVALID = ((state_q == S_EMIT) & ~bias_done_q) | (state_q == S_EMIT_BIAS);
    assign bus.new_o    = (state_q == S_EMIT) | (state_q == S_EMIT_BIAS);
    assign bus.i_TDATA  = win_q[tap_q];
    assign bus.k_TDATA  = wt_q[tap_q];
    assign bus.b_TDATA  = bias_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_LOAD;
            for (int j = 0; j < int'(TAPS); j++) begin
                win_q[j] <= '0;
                wt_q[j]  <= '0;
            end
            bias_q      <= '0;
            widx_q      <= '0;
            tap_q       <= '0;
            bias_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (bus.w_TVALID) begin
                        if (widx_q == WW'(TAPS)) begin
                            bias_q  <= bus.w_TDATA;
                            widx_q  <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            wt_q[TW'(widx_q)] <= bus.w_TDATA;
                            widx_q            <= widx_q + WW'(1);
                        end
                    end
                end

                // Reload takes priority over a sample offered in the same cycle
                S_IDLE: begin
                    if (bus.load_i) begin
                        widx_q  <= '0;
                        state_q <= S_LOAD;
                    end else if (bus.s_TVALID) begin
                        win_q[0] <= bus.s_TDATA;
                        for (int j = 1; j < int'(TAPS); j++) begin
                            win_q[j] <= win_q[j-1];
                        end
                        tap_q       <= '0;
                        bias_done_q <= 1'b0;
                        state_q     <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (bias_xfer) begin
                        bias_done_q <= 1'b1;
                    end
                    if (pair_xfer) begin
                        tap_q <= tap_q + TW'(1);
                        if (last_tap) begin
                            state_q <= (bias_done_q | bias_xfer) ? S_IDLE : S_EMIT_BIAS;
                        end
                    end
                end

                // All pairs sent; frame stays open until the bias goes out
                S_EMIT_BIAS: begin
                    if (bus.b_TREADY) begin
                        bias_done_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: state_q <= S_LOAD;
            endcase
        end
    end
endmodule

// File: doc/conv_feeder.md
# conv_feeder

Upstream operand feeder for the 8-bit stream MAC. Holds a TAPS-deep sliding window of input samples plus a loadable weight/bias set. For every accepted sample it streams TAPS (sample, weight) pairs and one bias word into the MAC's i/k/b stream inputs. It frames each burst with `new_o` so the MAC's control unit can tell a mid-frame stall from end-of-frame.

## Interface
- `TAPS`, default 4: window depth and pairs per frame; ≥2.
- `W`, default 8: data width of all streams.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low.
- `load_i`  in  1  request weight reload; honoured only in IDLE.
- `w_TVALID`  in  1  weight/bias load stream valid.
- `w_TREADY`  out  1  weight stream ready.
- `w_TDATA`  in  W  TAPS weights (index 0 first), then 1 bias word.
- `s_TVALID`  in  1  sample stream valid.
- `s_TREADY`  out  1  sample stream ready.
- `s_TDATA`  in  W  input sample.
- `i_TVALID`  out  1  window operand valid, to MAC.
- `i_TREADY`  in  1  MAC ready for i.
- `i_TDATA`  out  W  window operand.
- `k_TVALID`  out  1  weight operand valid; always equal to `i_TVALID`.
- `k_TREADY`  in  1  MAC ready for k.
- `k_TDATA`  out  W  weight operand.
- `b_TVALID`  out  1  bias valid.
- `b_TREADY`  in  1  MAC ready for bias.
- `b_TDATA`  out  W  bias register.
- `new_o`  out  1  frame-in-progress flag, to MAC `new_i`.

## Operation
- Storage:
  - window `win[0..TAPS-1]`, weights `wt[0..TAPS-1]`, bias register `bias`;
  - weight index counter `widx`, 0..TAPS;
  - tap counter `tap`, width clog2(TAPS);
  - flag `bias_done`.
- State LOAD (reset state):
  - `w_TREADY`=1.
  - Each `w_TVALID` beat writes `wt[widx]` for widx<TAPS, or `bias` when widx==TAPS, then increments widx.
  - The beat with widx==TAPS moves to IDLE and clears widx.
- State IDLE:
  - `s_TREADY` = !`load_i`.
  - `load_i`=1 → LOAD, widx=0. Load wins over a simultaneous `s_TVALID`, and that sample is not accepted.
  - Sample accept (`s_TVALID` & `s_TREADY`):
    - shift the window: `win[0]`←`s_TDATA`, `win[j]`←`win[j-1]`; the oldest sample is dropped;
    - `tap`←0, `bias_done`←0;
    - → EMIT.
- State EMIT:
  - `i_TVALID`=`k_TVALID`=1, `i_TDATA`=`win[tap]`, `k_TDATA`=`wt[tap]`, `new_o`=1.
  - `b_TVALID` = !`bias_done`.
  - Pair transfer = `i_TVALID` & `i_TREADY` & `k_TREADY`; on transfer `tap` increments.
  - Bias transfer = `b_TVALID` & `b_TREADY` sets `bias_done`.
  - Frame complete when the pair at tap==TAPS-1 transfers and the bias is done (already or in the same cycle) → IDLE.
  - If the last pair transfers before the bias, hold in EMIT:
    - `i_TVALID`/`k_TVALID`=0, `new_o`=1, `b_TVALID`=1;
    - leave when the bias transfers;
    - mark this sub-state internally as EMIT_BIAS.
- `b_TDATA` = `bias` at all times.
- `load_i` outside IDLE is ignored (not latched).
- `s_TREADY`=0 and `w_TREADY`=0 outside IDLE and LOAD respectively.
- No arithmetic is performed; data pass through unmodified at width W.

## Timing
- Reset (`reset`=0 at a clock edge):
  - state→LOAD; win, wt, bias, widx, tap cleared to 0; `bias_done`←0.
  - After the edge: `w_TREADY`=1; `s_TREADY`, all *_TVALID and `new_o`=0.
- Reset mid-EMIT or mid-LOAD aborts immediately with the same values. Partial weight loads are discarded (cleared).
- Outputs are decoded from registered state/counters; no combinational path from `s_TVALID` or `w_TVALID` to any output.
- Exception: `s_TREADY` depends combinationally on `load_i`.
- Sample accepted at edge n → first pair and bias valid in cycle n+1.
- With the MAC always ready, the frame occupies cycles n+1..n+TAPS; IDLE in n+TAPS+1.
- Sustained rate: one sample per TAPS+1 cycles.
- Backpressure: while a pair is not transferred, `i_TDATA`, `k_TDATA`, `tap` and `new_o` stay stable. `new_o` never drops mid-frame.
- `new_o` and `i_TVALID` fall in the same cycle after the final transfer. The MAC sees valid low with `new_i` low and so recognises end-of-frame.

## Test plan
- Load, single sample:
  - load weights 1,2,3,4 and bias 5, then sample 10;
  - pairs (10,1),(0,2),(0,3),(0,4) on consecutive cycles; bias 5 accepted with the first pair;
  - `new_o` high exactly 4 cycles.
- Window shift:
  - follow with samples 20 then 30;
  - frames (20,1),(10,2),(0,3),(0,4), then (30,1),(20,2),(10,3),(0,4).
- Backpressure:
  - drop `i_TREADY` for 3 cycles while tap=2;
  - `i_TDATA`=`win[2]` and `k_TDATA`=3 held, `new_o` stays 1, no tap skipped or repeated.
- Late bias:
  - hold `b_TREADY`=0 until 2 cycles after the last pair;
  - `i_TVALID`=0 and `new_o`=1 while waiting; IDLE on the cycle after the bias transfers.
- Load/sample collision:
  - in IDLE assert `load_i` and `s_TVALID` together;
  - `s_TREADY`=0, state LOAD, window unchanged; reload 9,9,9,9 bias 0; the next sample uses weights 9.
- Reset mid-frame:
  - pull `reset` low at tap=1;
  - next cycle all valids and `new_o`=0, `w_TREADY`=1; after reload, the first frame shows an all-zero window except `win[0]`.
